load_store_unit: RTL and testbench

Multi-cycle data-memory access unit between the execute stage and the data-memory bus. It consumes the decoder's MemWrite, MemRead and AddressingControl (funct3) together with the ALU-computed address and store data. It performs a single request/acknowledge transaction on a word-wide memory bus. Load data comes back aligned and sign- or zero-extended for register writeback. While an access is in flight it stalls the core.

---
 rtl/load_store_unit.sv | 186 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle data-memory access between execute and a word-wide
// request/acknowledge bus. Stalls the core while an access is in flight, reports
// misaligned/illegal accesses as a fault without touching the bus, and returns
// load data lane-selected and sign/zero-extended.
module load_store_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            AddressingControl,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  stall,
  output logic                  done,
  output logic                  fault,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [DATA_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_be,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                state_q, state_d;
  logic                  req_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [3:0]            be_q;
  logic [DATA_WIDTH-1:0] bwdata_q;
  logic [1:0]            lane_q;
  logic [2:0]            f3_q;
  logic                  fault_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  is_access;
  logic                  width_ok;
  logic                  misaligned;
  logic                  req_fault;
  logic [3:0]            be_d;
  logic [DATA_WIDTH-1:0] bwdata_d;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] load_fmt;
  logic                  accept;
  logic                  accept_fault;
  logic                  capture;

  assign is_access = MemRead | MemWrite;

  // Decode the request: legality, alignment, byte enables and lane-replicated store data.
  always_comb begin
    width_ok   = 1'b0;
    misaligned = 1'b0;
    be_d       = 4'b1111;
    bwdata_d   = wdata;
    if (MemWrite) begin
      width_ok = ~AddressingControl[2] & (AddressingControl[1:0] != 2'b11);
    end else begin
      // Loads also allow the unsigned forms 100 and 101.
      width_ok = (AddressingControl[1:0] != 2'b11) &
                 ~(AddressingControl[2] & AddressingControl[1]);
    end
    unique case (AddressingControl[1:0])
      2'b00: begin
        be_d     = 4'b0001 << addr[1:0];
        bwdata_d = {4{wdata[7:0]}};
      end
      2'b01: begin
        misaligned = addr[0];
        be_d       = addr[1] ? 4'b1100 : 4'b0011;
        bwdata_d   = {2{wdata[15:0]}};
      end
      2'b10: begin
        misaligned = (addr[1:0] != 2'b00);
      end
      default: begin
        misaligned = 1'b0;
      end
    endcase
    req_fault = (MemRead & MemWrite) | ~width_ok | misaligned;
  end

  // Pick the addressed lane of the returned word and extend it for writeback.
  always_comb begin
    unique case (lane_q)
      2'b00:   byte_sel = bus_rdata[7:0];
      2'b01:   byte_sel = bus_rdata[15:8];
      2'b10:   byte_sel = bus_rdata[23:16];
      default: byte_sel = bus_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    unique case (f3_q)
      3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_fmt = {24'b0, byte_sel};
      3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_fmt = {16'b0, half_sel};
      default: load_fmt = bus_rdata;
    endcase
  end

  // Next-state and stall/handshake control.
  always_comb begin
    state_d      = state_q;
    stall        = 1'b0;
    accept       = 1'b0;
    accept_fault = 1'b0;
    capture      = 1'b0;
    unique case (state_q)
      StIdle: begin
        stall = is_access;
        if (is_access) begin
          if (req_fault) begin
            accept_fault = 1'b1;
            state_d      = StResp;
          end else begin
            accept  = 1'b1;
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        stall = 1'b1;
        if (bus_ack) begin
          capture = ~we_q;
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, latched request and load result; bus outputs only change on a new valid access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= 4'b0000;
      bwdata_q <= '0;
      lane_q   <= 2'b00;
      f3_q     <= 3'b000;
      fault_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= (state_d == StBusy);
      if (accept) begin
        we_q     <= MemWrite;
        addr_q   <= {addr[DATA_WIDTH-1:2], 2'b00};
        be_q     <= be_d;
        bwdata_q <= bwdata_d;
        lane_q   <= addr[1:0];
        f3_q     <= AddressingControl;
        fault_q  <= 1'b0;
      end
      if (accept_fault) begin
        fault_q <= 1'b1;
      end
      if (capture) begin
        rdata_q <= load_fmt;
      end
    end
  end

  assign done      = (state_q == StResp);
  assign fault     = done & fault_q;
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = bwdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: reset behaviour, a table of directed
// accesses, a reset-abort sequence and randomized accesses against a reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  AddressingControl = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        stall;
  logic        done;
  logic        fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_rdata = '0;

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .AddressingControl(AddressingControl), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .done(done), .fault(fault), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rword;
    int          waits;
    logic        efault;
    logic [3:0]  ebe;
    logic [31:0] ebwd;
    logic [31:0] erdata;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model computed from the access rules with plain arithmetic.
  function automatic void model(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rword, input logic [31:0] prev,
                                output logic flt, output logic [3:0] be,
                                output logic [31:0] bwd, output logic [31:0] rout);
    int bytes;
    int off;
    logic legal;
    logic [63:0] mask;
    logic [63:0] val;
    bytes = 1 << f3[1:0];
    off   = int'(a % 4);
    if (rd && wr)  legal = 1'b0;
    else if (rd)   legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    else           legal = f3 inside {3'd0, 3'd1, 3'd2};
    flt  = !legal || ((off % bytes) != 0);
    be   = 4'(((1 << bytes) - 1) << off);
    if (bytes == 1)      bwd = 32'(wd[7:0]) * 32'h0101_0101;
    else if (bytes == 2) bwd = 32'(wd[15:0]) * 32'h0001_0001;
    else                 bwd = wd;
    rout = prev;
    if (rd && !flt) begin
      mask = (64'd1 << (8 * bytes)) - 64'd1;
      val  = (64'(rword) >> (8 * off)) & mask;
      if (!f3[2] && bytes < 4 && val[8 * bytes - 1]) val = val | ~mask;
      rout = val[31:0];
    end
  endfunction

  // One access from issue to its done cycle; leaves inputs held through the done cycle.
  task automatic do_access(input vec_t v, input string tag);
    @(posedge clk); #1;
    MemRead = v.rd; MemWrite = v.wr; AddressingControl = v.f3;
    addr = v.a; wdata = v.wd; bus_rdata = v.rword; bus_ack = 1'b0;
    #1;
    check({tag, ".issue_stall"}, 32'(stall), 32'd1);
    check({tag, ".issue_req"}, 32'(bus_req), 32'd0);
    check({tag, ".issue_done"}, 32'(done), 32'd0);
    if (!v.efault) begin
      for (int i = 0; i <= v.waits; i++) begin
        @(posedge clk); #1;
        bus_ack = (i == v.waits);
        #1;
        check({tag, ".busy_req"}, 32'(bus_req), 32'd1);
        check({tag, ".busy_stall"}, 32'(stall), 32'd1);
        check({tag, ".busy_done"}, 32'(done), 32'd0);
        check({tag, ".bus_we"}, 32'(bus_we), 32'(v.wr));
        check({tag, ".bus_addr"}, bus_addr, v.a & ~32'd3);
        check({tag, ".bus_be"}, 32'(bus_be), 32'(v.ebe));
        if (v.wr) check({tag, ".bus_wdata"}, bus_wdata, v.ebwd);
      end
    end
    @(posedge clk); #1;
    bus_ack = 1'b0;
    #1;
    check({tag, ".resp_done"}, 32'(done), 32'd1);
    check({tag, ".resp_fault"}, 32'(fault), 32'(v.efault));
    check({tag, ".resp_stall"}, 32'(stall), 32'd0);
    check({tag, ".resp_req"}, 32'(bus_req), 32'd0);
    check({tag, ".rdata"}, rdata, v.erdata);
    model_rdata = v.erdata;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0; bus_ack = 1'b0;
    #1;
    check("idle.stall", 32'(stall), 32'd0);
    check("idle.done", 32'(done), 32'd0);
    check("idle.req", 32'(bus_req), 32'd0);
  endtask

  initial begin
    //        rd    wr    f3    addr          wdata         rword         w  flt   be       bwd           rdata
    tbl[0]  = '{1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 1'b0, 4'b1000, 32'h0, 32'hFFFF_FF80};
    tbl[1]  = '{1'b1, 1'b0, 3'd4, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 1'b0, 4'b1000, 32'h0, 32'h0000_0080};
    tbl[2]  = '{1'b0, 1'b1, 3'd1, 32'h0000_0202, 32'hDEAD_BEEF, 32'h5555_5555, 3, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0080};
    tbl[3]  = '{1'b1, 1'b0, 3'd2, 32'h0000_0006, 32'h0,        32'h1234_5678, 0, 1'b1, 4'b0000, 32'h0, 32'h0000_0080};
    tbl[4]  = '{1'b1, 1'b1, 3'd2, 32'h0000_0010, 32'h0,        32'h1234_5678, 0, 1'b1, 4'b0000, 32'h0, 32'h0000_0080};
    tbl[5]  = '{1'b1, 1'b0, 3'd3, 32'h0000_0008, 32'h0,        32'h1234_5678, 0, 1'b1, 4'b0000, 32'h0, 32'h0000_0080};
    tbl[6]  = '{1'b1, 1'b0, 3'd5, 32'h0000_0302, 32'h0,        32'h9ABC_0000, 0, 1'b0, 4'b1100, 32'h0, 32'h0000_9ABC};
    tbl[7]  = '{1'b0, 1'b1, 3'd2, 32'h0000_0304, 32'h1234_5678, 32'h9ABC_0000, 0, 1'b0, 4'b1111, 32'h1234_5678, 32'h0000_9ABC};
    tbl[8]  = '{1'b1, 1'b0, 3'd1, 32'h0000_0000, 32'h0,        32'h0000_8001, 1, 1'b0, 4'b0011, 32'h0, 32'hFFFF_8001};
    tbl[9]  = '{1'b0, 1'b1, 3'd0, 32'h0000_0001, 32'h0000_00A5, 32'h0,        2, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'hFFFF_8001};
    tbl[10] = '{1'b0, 1'b1, 3'd4, 32'h0000_0020, 32'h0000_0011, 32'h0,        0, 1'b1, 4'b0000, 32'h0, 32'hFFFF_8001};
    tbl[11] = '{1'b1, 1'b0, 3'd1, 32'h0000_0001, 32'h0,        32'hFFFF_FFFF, 0, 1'b1, 4'b0000, 32'h0, 32'hFFFF_8001};
    tbl[12] = '{1'b1, 1'b0, 3'd0, 32'h0000_0001, 32'h0,        32'h0000_7F00, 0, 1'b0, 4'b0010, 32'h0, 32'h0000_007F};

    // Reset held with a load pending, then released.
    rst = 1'b1; MemRead = 1'b1; AddressingControl = 3'd2; addr = 32'h40;
    bus_rdata = 32'h1122_3344;
    repeat (2) @(posedge clk);
    #1;
    check("rst.req", 32'(bus_req), 32'd0);
    check("rst.rdata", rdata, 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.fault", 32'(fault), 32'd0);
    check("rst.we", 32'(bus_we), 32'd0);
    check("rst.addr", bus_addr, 32'd0);
    check("rst.be", 32'(bus_be), 32'd0);
    check("rst.wdata", bus_wdata, 32'd0);
    check("rst.stall", 32'(stall), 32'd1);
    rst = 1'b0;
    #1;
    check("post_rst.req", 32'(bus_req), 32'd0);
    check("post_rst.rdata", rdata, 32'd0);
    @(posedge clk); #1;
    bus_ack = 1'b1;
    #1;
    check("post_rst.req1", 32'(bus_req), 32'd1);
    check("post_rst.be", 32'(bus_be), 32'hF);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    #1;
    check("post_rst.done", 32'(done), 32'd1);
    check("post_rst.rdata_lw", rdata, 32'h1122_3344);

    // Directed table, issued back to back.
    for (int i = 0; i < 13; i++) do_access(tbl[i], $sformatf("tbl%0d", i));
    idle_cycle();

    // Reset during the second BUSY cycle; the late ack must be ignored.
    @(posedge clk); #1;
    MemRead = 1'b1; MemWrite = 1'b0; AddressingControl = 3'd2; addr = 32'h50;
    bus_rdata = 32'hCAFE_F00D;
    #1;
    check("abort.issue_stall", 32'(stall), 32'd1);
    @(posedge clk); #2;
    check("abort.busy1_req", 32'(bus_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; MemRead = 1'b0;
    #1;
    check("abort.busy2_req", 32'(bus_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort.req_drop", 32'(bus_req), 32'd0);
    check("abort.done0", 32'(done), 32'd0);
    @(posedge clk); #1;
    bus_ack = 1'b1;
    #1;
    check("abort.late_ack_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    #1;
    check("abort.done2", 32'(done), 32'd0);
    check("abort.rdata", rdata, 32'd0);
    model_rdata = 32'd0;

    // Randomized accesses against the reference model.
    for (int n = 0; n < 60; n++) begin
      vec_t v;
      int   op;
      op      = int'($urandom_range(0, 9));
      v.rd    = (op <= 4) || (op == 9);
      v.wr    = (op >= 5);
      v.f3    = 3'($urandom_range(0, 7));
      v.a     = $urandom;
      v.wd    = $urandom;
      v.rword = $urandom;
      v.waits = int'($urandom_range(0, 3));
      model(v.rd, v.wr, v.f3, v.a, v.wd, v.rword, model_rdata,
            v.efault, v.ebe, v.ebwd, v.erdata);
      do_access(v, $sformatf("rnd%0d", n));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
